cpu_decode_stage: RTL and testbench
===================================

CPU_DECODE_STAGE -- requirements
Module: cpu_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc and immediate; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, output queue entries; power of two, 2..8.
REQ-003 i_clock  input  1  single clock; all state on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous and active-high.
REQ-005 i_valid  input  1  upstream entry present.
REQ-006 o_ready  output  1  stage accepts an entry this cycle.
REQ-007 i_pc  input  XLEN  pc of the upstream instruction.
REQ-008 i_instruction  input  32  raw instruction word.
REQ-009 i_flush  input  1  discard all queued and incoming entries.
REQ-010 o_valid  output  1  head entry present.
REQ-011 i_ready  input  1  downstream consumes the head entry.
REQ-012 o_data  output  decode_entry_t  head entry: pc, rs1/rs2/rs3/rd, have_rs[2:0], imm, fmt (one-hot), illegal, fpu.
REQ-013 o_fault  output  1  sticky illegal-instruction flag.
REQ-014 o_fault_pc  output  XLEN  pc of the first illegal instruction since clear.
REQ-015 i_fault_clear  input  1  clears o_fault and o_fault_pc.

Function
REQ-016 Transfer in when i_valid and o_ready are both high; transfer out when o_valid and i_ready are both high.
REQ-017 o_ready is high exactly when the registered count is below DEPTH; it depends on no same-cycle input.
REQ-018 An entry accepted at edge N is visible on o_data at the earliest after edge N; latency 1 cycle when empty.
REQ-019 Simultaneous push and pop keep the count unchanged; pointers wrap modulo DEPTH.
REQ-020 Format is decoded from i_instruction[6:0]: 0x37/0x17 U; 0x6F J; 0x67/0x03/0x13/0x0F I; 0x63 B; 0x23 S; 0x33 R; 0x73 CSR when funct3 is nonzero, else I.
REQ-021 Immediate per format: B, I, J, S sign-extended from bit 31 to XLEN; U is bits[31:12] followed by 12 zeros, then sign-extended; R is shamt {instruction[25:20]}, zero-extended; CSR is instruction[31:20], zero-extended; otherwise zero.
REQ-022 have_rs bit k is set when format k uses that source and its register index is nonzero; bit order {rs3, rs2, rs1}.
REQ-023 Illegal when instruction[1:0] != 2'b11 or opcode is unlisted; an illegal entry is still enqueued with illegal=1, fmt=0, have_rs=0.
REQ-024 On accepting an illegal entry while o_fault is low, the stage sets o_fault and captures o_fault_pc; later illegals do not overwrite it.
REQ-025 If i_fault_clear coincides with an illegal accept, the clear wins and the fault is not set.
REQ-026 i_flush empties the queue at the next edge; an input offered in the same cycle is dropped and raises no fault.
REQ-027 Flush does not clear o_fault.

Reset
REQ-028 While i_reset is high: count zero, o_valid 0, o_fault 0, o_fault_pc 0, o_data all zero; o_ready rises on the first edge after release.

Configuration
REQ-029 With CPU_DECODE_FPU_EN defined, opcodes 0x07/0x27 decode as I/S, 0x43/0x47/0x4B/0x4F decode as R4 (rs3 = instruction[31:27]), 0x53 decodes as R, and fpu=1 for all of these.
REQ-030 Without CPU_DECODE_FPU_EN, those opcodes are illegal, the fpu field is tied to 0, and have_rs[2] is always 0.

Structure
REQ-031 Package cpu_decode_pkg holds decode_entry_t, the opcode constants and the one-hot format constants (U, J, I, B, S, R, CSR, R4).
REQ-032 Sub-module cpu_decode_fifo (parameters DEPTH and entry type) holds the queue, pointers and count; decode logic stays combinational in front of it.

Verification
REQ-033 Push 0xFFF10093 at pc 0x100 -> next cycle o_valid=1, fmt I, rs1=2, rd=1, imm=0xFFFFFFFF, have_rs=3'b001.
REQ-034 Push 0x00208463 (beq x1,x2,+8) -> fmt B, imm=8, have_rs=3'b011.
REQ-035 i_ready=0 with DEPTH=2 and three pushes -> o_ready low after the second push; the third entry is held until one pop.
REQ-036 Push 0x00000000 at pc 0x200, then an illegal at 0x204 -> illegal=1, o_fault=1, o_fault_pc=0x200; pulsing i_fault_clear -> o_fault=0.
REQ-037 Queue holding 2 entries with i_flush and i_valid both high -> next cycle o_valid=0 and the count is zero.
REQ-038 Push 0x0020F0D3 (fadd.s) -> with CPU_DECODE_FPU_EN: fpu=1, fmt R; without it: illegal=1.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// Shared types and constants for the decode stage: opcode map, one-hot format codes,
// and the queued entry layout (pc/imm sized for the widest legal XLEN).
package cpu_decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_OP_IMM   = 7'h13;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_OP       = 7'h33;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;
  localparam logic [6:0] OP_LOAD_FP  = 7'h07;
  localparam logic [6:0] OP_STORE_FP = 7'h27;
  localparam logic [6:0] OP_MADD     = 7'h43;
  localparam logic [6:0] OP_MSUB     = 7'h47;
  localparam logic [6:0] OP_NMSUB    = 7'h4B;
  localparam logic [6:0] OP_NMADD    = 7'h4F;
  localparam logic [6:0] OP_OP_FP    = 7'h53;

  typedef logic [7:0] fmt_t;

  localparam fmt_t FMT_U   = 8'b0000_0001;
  localparam fmt_t FMT_J   = 8'b0000_0010;
  localparam fmt_t FMT_I   = 8'b0000_0100;
  localparam fmt_t FMT_B   = 8'b0000_1000;
  localparam fmt_t FMT_S   = 8'b0001_0000;
  localparam fmt_t FMT_R   = 8'b0010_0000;
  localparam fmt_t FMT_CSR = 8'b0100_0000;
  localparam fmt_t FMT_R4  = 8'b1000_0000;

  // Bits of pc/imm above the configured XLEN are always zero.
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rs3;
    logic [4:0]          rd;
    logic [2:0]          have_rs;
    logic [XLEN_MAX-1:0] imm;
    fmt_t                fmt;
    logic                illegal;
    logic                fpu;
  } decode_entry_t;

  // Source-register usage per format, ordered {rs3, rs2, rs1}.
  function automatic logic [2:0] src_use(input fmt_t f);
    src_use[0] = |(f & (FMT_I | FMT_B | FMT_S | FMT_R | FMT_CSR | FMT_R4));
    src_use[1] = |(f & (FMT_B | FMT_S | FMT_R | FMT_R4));
    src_use[2] = |(f & FMT_R4);
  endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// Upstream/downstream handshake, head entry and fault reporting for cpu_decode_stage.
interface cpu_decode_if #(parameter int XLEN = 32);
  import cpu_decode_pkg::*;

  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_pc;
  logic [31:0]     i_instruction;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  decode_entry_t   o_data;
  logic            o_fault;
  logic [XLEN-1:0] o_fault_pc;
  logic            i_fault_clear;

  modport slave (
    input  i_valid, i_pc, i_instruction, i_flush, i_ready, i_fault_clear,
    output o_ready, o_valid, o_data, o_fault, o_fault_pc
  );

  modport master (
    output i_valid, i_pc, i_instruction, i_flush, i_ready, i_fault_clear,
    input  o_ready, o_valid, o_data, o_fault, o_fault_pc
  );

endinterface

// File: rtl/cpu_decode_fifo.sv
// Power-of-two entry queue with registered count; ready/valid derive from registered state only.
module cpu_decode_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t push_data,
  output entry_t pop_data,
  output logic   ready,
  output logic   valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            live;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign valid    = (count != '0);
  assign ready    = live && (count < CW'(DEPTH));
  assign pop_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cpu_decode_stage.sv
// Instruction decode stage: combinational decode feeding a small output queue, plus sticky fault capture.
// Define CPU_DECODE_FPU_EN to decode the floating-point opcode group (I/S/R/R4 with fpu=1).
module cpu_decode_stage
  import cpu_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic       i_clock,
  input logic       i_reset,
  cpu_decode_if.slave bus
);

  localparam logic [XLEN_MAX-1:0] IMM_MASK = (XLEN == 64) ? {XLEN_MAX{1'b1}}
                                           : {{(XLEN_MAX-32){1'b0}}, 32'hFFFF_FFFF};

  logic [31:0]         ins;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  fmt_t                fmt;
  logic                fpu;
  logic [XLEN_MAX-1:0] imm;
  decode_entry_t       entry;
  logic                push;
  logic                pop;
  logic                fault_q;
  logic [XLEN-1:0]     fault_pc_q;

  assign ins    = bus.i_instruction;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];

  always_comb begin
    fmt = '0;
    fpu = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC:                        fmt = FMT_U;
      OP_JAL:                                  fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_OP_IMM, OP_MISC_MEM: fmt = FMT_I;
      OP_BRANCH:                               fmt = FMT_B;
      OP_STORE:                                fmt = FMT_S;
      OP_OP:                                   fmt = FMT_R;
      OP_SYSTEM:                               fmt = (funct3 != 3'd0) ? FMT_CSR : FMT_I;
`ifdef CPU_DECODE_FPU_EN
      OP_LOAD_FP:  begin fmt = FMT_I; fpu = 1'b1; end
      OP_STORE_FP: begin fmt = FMT_S; fpu = 1'b1; end
      OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD: begin fmt = FMT_R4; fpu = 1'b1; end
      OP_OP_FP:    begin fmt = FMT_R; fpu = 1'b1; end
`endif
      default:                                 fmt = '0;
    endcase
    // Compressed / non-32-bit encodings are rejected regardless of opcode.
    if (ins[1:0] != 2'b11) begin
      fmt = '0;
      fpu = 1'b0;
    end
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{52{ins[31]}}, ins[31:20]};
      FMT_S:   imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_J:   imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_U:   imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      FMT_R:   imm = {58'b0, ins[25:20]};
      FMT_CSR: imm = {52'b0, ins[31:20]};
      default: imm = '0;
    endcase
  end

  always_comb begin
    entry         = '0;
    entry.pc      = XLEN_MAX'(bus.i_pc);
    entry.rs1     = ins[19:15];
    entry.rs2     = ins[24:20];
    entry.rs3     = ins[31:27];
    entry.rd      = ins[11:7];
    entry.have_rs = src_use(fmt) & {ins[31:27] != 5'd0, ins[24:20] != 5'd0, ins[19:15] != 5'd0};
    entry.imm     = imm & IMM_MASK;
    entry.fmt     = fmt;
    entry.illegal = (fmt == '0);
    entry.fpu     = fpu;
  end

  assign push = bus.i_valid && bus.o_ready && !bus.i_flush;
  assign pop  = bus.o_valid && bus.i_ready;

  cpu_decode_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (decode_entry_t)
  ) u_fifo (
    .clk       (i_clock),
    .rst       (i_reset),
    .push      (push),
    .pop       (pop),
    .flush     (bus.i_flush),
    .push_data (entry),
    .pop_data  (bus.o_data),
    .ready     (bus.o_ready),
    .valid     (bus.o_valid)
  );

  // A clear in the same cycle as an illegal accept takes priority.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (bus.i_fault_clear) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (push && entry.illegal && !fault_q) begin
      fault_q    <= 1'b1;
      fault_pc_q <= bus.i_pc;
    end
  end

  assign bus.o_fault    = fault_q;
  assign bus.o_fault_pc = fault_pc_q;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Directed bench for cpu_decode_stage (XLEN=32, DEPTH=2) with hand-computed expectations.
module tb_cpu_decode_stage;

  localparam logic [7:0] E_U   = 8'h01;
  localparam logic [7:0] E_J   = 8'h02;
  localparam logic [7:0] E_I   = 8'h04;
  localparam logic [7:0] E_B   = 8'h08;
  localparam logic [7:0] E_S   = 8'h10;
  localparam logic [7:0] E_R   = 8'h20;
  localparam logic [7:0] E_CSR = 8'h40;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] v_ins  [6];
  logic [7:0]  v_fmt  [6];
  logic [63:0] v_imm  [6];
  logic [2:0]  v_have [6];

  cpu_decode_if #(.XLEN(32)) bus ();

  cpu_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.i_valid       = v;
    bus.i_pc          = pc;
    bus.i_instruction = ins;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    v_ins[0] = 32'h123450B7; v_fmt[0] = E_U;   v_imm[0] = 64'h0000_0000_1234_5000; v_have[0] = 3'b000;
    v_ins[1] = 32'h008000EF; v_fmt[1] = E_J;   v_imm[1] = 64'h0000_0000_0000_0008; v_have[1] = 3'b000;
    v_ins[2] = 32'hFE112E23; v_fmt[2] = E_S;   v_imm[2] = 64'h0000_0000_FFFF_FFFC; v_have[2] = 3'b011;
    v_ins[3] = 32'h30001073; v_fmt[3] = E_CSR; v_imm[3] = 64'h0000_0000_0000_0300; v_have[3] = 3'b000;
    v_ins[4] = 32'h00000073; v_fmt[4] = E_I;   v_imm[4] = 64'h0000_0000_0000_0000; v_have[4] = 3'b000;
    v_ins[5] = 32'h403100B3; v_fmt[5] = E_R;   v_imm[5] = 64'h0000_0000_0000_0003; v_have[5] = 3'b011;

    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    bus.i_flush       = 1'b0;
    bus.i_ready       = 1'b0;
    bus.i_fault_clear = 1'b0;
    tick();
    tick();
    check("rst_valid",    64'(bus.o_valid), 64'd0);
    check("rst_ready",    64'(bus.o_ready), 64'd0);
    check("rst_fault",    64'(bus.o_fault), 64'd0);
    check("rst_fault_pc", 64'(bus.o_fault_pc), 64'd0);
    check("rst_data_zero", 64'(bus.o_data === '0), 64'd1);

    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(bus.o_ready), 64'd1);
    check("post_rst_valid", 64'(bus.o_valid), 64'd0);

    // Fill with downstream stalled.
    drive(1'b1, 32'h100, 32'hFFF10093);
    tick();
    check("addi_valid", 64'(bus.o_valid), 64'd1);
    check("addi_fmt",   64'(bus.o_data.fmt), 64'(E_I));
    check("addi_rs1",   64'(bus.o_data.rs1), 64'd2);
    check("addi_rd",    64'(bus.o_data.rd), 64'd1);
    check("addi_imm",   bus.o_data.imm, 64'h0000_0000_FFFF_FFFF);
    check("addi_have",  64'(bus.o_data.have_rs), 64'(3'b001));
    check("addi_ready", 64'(bus.o_ready), 64'd1);

    drive(1'b1, 32'h104, 32'h00208463);
    tick();
    check("full_ready", 64'(bus.o_ready), 64'd0);
    check("full_head_pc", bus.o_data.pc, 64'h100);

    drive(1'b1, 32'h108, 32'h002081B3);
    tick();
    check("held_ready", 64'(bus.o_ready), 64'd0);
    check("held_head_pc", bus.o_data.pc, 64'h100);

    bus.i_ready = 1'b1;
    tick();
    check("beq_pc",    bus.o_data.pc, 64'h104);
    check("beq_fmt",   64'(bus.o_data.fmt), 64'(E_B));
    check("beq_imm",   bus.o_data.imm, 64'd8);
    check("beq_have",  64'(bus.o_data.have_rs), 64'(3'b011));
    check("beq_ready", 64'(bus.o_ready), 64'd1);

    bus.i_ready = 1'b0;
    tick();
    check("third_in_ready", 64'(bus.o_ready), 64'd0);

    drive(1'b0, 32'h0, 32'h0);
    bus.i_ready = 1'b1;
    tick();
    check("add_pc",   bus.o_data.pc, 64'h108);
    check("add_fmt",  64'(bus.o_data.fmt), 64'(E_R));
    check("add_rd",   64'(bus.o_data.rd), 64'd3);
    check("add_imm",  bus.o_data.imm, 64'd2);
    check("add_have", 64'(bus.o_data.have_rs), 64'(3'b011));
    tick();
    check("drained_valid", 64'(bus.o_valid), 64'd0);

    // Sticky fault capture and clear.
    drive(1'b1, 32'h200, 32'h00000000);
    tick();
    check("ill0_illegal", 64'(bus.o_data.illegal), 64'd1);
    check("ill0_fmt",     64'(bus.o_data.fmt), 64'd0);
    check("ill0_have",    64'(bus.o_data.have_rs), 64'd0);
    check("ill0_fault",   64'(bus.o_fault), 64'd1);
    check("ill0_fpc",     64'(bus.o_fault_pc), 64'h200);

    drive(1'b1, 32'h204, 32'hFFFFFFFF);
    tick();
    check("ill1_pc",      bus.o_data.pc, 64'h204);
    check("ill1_illegal", 64'(bus.o_data.illegal), 64'd1);
    check("ill1_fpc_kept", 64'(bus.o_fault_pc), 64'h200);

    drive(1'b0, 32'h0, 32'h0);
    bus.i_fault_clear = 1'b1;
    tick();
    check("clr_fault", 64'(bus.o_fault), 64'd0);
    check("clr_fpc",   64'(bus.o_fault_pc), 64'd0);

    drive(1'b1, 32'h300, 32'h00000001);
    tick();
    check("clrwin_fault",   64'(bus.o_fault), 64'd0);
    check("clrwin_illegal", 64'(bus.o_data.illegal), 64'd1);
    bus.i_fault_clear = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Streaming through with downstream always ready.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), v_ins[i]);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.o_valid), 64'd1);
      check($sformatf("vec%0d_fmt", i),   64'(bus.o_data.fmt), 64'(v_fmt[i]));
      check($sformatf("vec%0d_imm", i),   bus.o_data.imm, v_imm[i]);
      check($sformatf("vec%0d_have", i),  64'(bus.o_data.have_rs), 64'(v_have[i]));
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Flush with a full queue and an illegal offered the same cycle.
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h00000013);
    tick();
    drive(1'b1, 32'h404, 32'h00000013);
    tick();
    check("pre_flush_ready", 64'(bus.o_ready), 64'd0);
    bus.i_flush = 1'b1;
    drive(1'b1, 32'h408, 32'h00000000);
    tick();
    check("flush_valid", 64'(bus.o_valid), 64'd0);
    check("flush_ready", 64'(bus.o_ready), 64'd1);
    check("flush_fault", 64'(bus.o_fault), 64'd0);
    bus.i_flush = 1'b0;
    drive(1'b1, 32'h40C, 32'h00000013);
    tick();
    check("post_flush_pc",    bus.o_data.pc, 64'h40C);
    check("post_flush_ready", 64'(bus.o_ready), 64'd1);
    bus.i_flush = 1'b1;
    drive(1'b1, 32'h410, 32'h00000000);
    tick();
    check("flush1_valid", 64'(bus.o_valid), 64'd0);
    check("flush1_fault", 64'(bus.o_fault), 64'd0);
    bus.i_flush = 1'b0;

    // Flush must leave a captured fault in place.
    bus.i_ready = 1'b1;
    drive(1'b1, 32'h500, 32'h00000002);
    tick();
    check("fault2_set", 64'(bus.o_fault), 64'd1);
    check("fault2_pc",  64'(bus.o_fault_pc), 64'h500);
    drive(1'b0, 32'h0, 32'h0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("flush_keeps_fault", 64'(bus.o_fault), 64'd1);
    check("flush_keeps_fpc",   64'(bus.o_fault_pc), 64'h500);

    drive(1'b1, 32'h600, 32'h0020F0D3);
    tick();
`ifdef CPU_DECODE_FPU_EN
    check("fadd_fpu",     64'(bus.o_data.fpu), 64'd1);
    check("fadd_fmt",     64'(bus.o_data.fmt), 64'(E_R));
    check("fadd_illegal", 64'(bus.o_data.illegal), 64'd0);
`else
    check("fadd_fpu",     64'(bus.o_data.fpu), 64'd0);
    check("fadd_fmt",     64'(bus.o_data.fmt), 64'd0);
    check("fadd_illegal", 64'(bus.o_data.illegal), 64'd1);
`endif
    drive(1'b0, 32'h0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
